// File: rtl/jtframe_dump_pkg.sv
// jtframe_dump_pkg
//   Shared definitions for the dump-window trigger: default counter width
//   and the encoding of the trigger FSM state that is exported on the st
//   debug port.
package jtframe_dump_pkg;

  // Default frame counter width
  localparam int CNTW_DEF = 32;

  // Encoding of the st debug output
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ARMED = 2'd1;
  localparam logic [1:0] ST_DUMP  = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE  = ST_IDLE,
    S_ARMED = ST_ARMED,
    S_DUMP  = ST_DUMP,
    S_DONE  = ST_DONE
  } state_t;

endpackage

// File: rtl/jtframe_sync_edge.sv
// jtframe_sync_edge
//   Brings an asynchronous level into the clk domain through SYNC flops and
//   derives single-cycle rise/fall pulses from a delay flop behind the
//   synchroniser.
// Ports
//   clk    in   system clock
//   rst_n  in   asynchronous reset, active low (all flops clear to 0)
//   din    in   asynchronous input level
//   rise   out  one-cycle pulse on a synchronised 0->1 transition
//   fall   out  one-cycle pulse on a synchronised 1->0 transition
module jtframe_sync_edge #(
  parameter int SYNC = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic rise,
  output logic fall
);

  logic [SYNC-1:0] sync_reg;
  logic            dly_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_reg <= '0;
      dly_reg  <= 1'b0;
    end else begin
      sync_reg <= {sync_reg[SYNC-2:0], din};
      dly_reg  <= sync_reg[SYNC-1];
    end
  end

  // Pulses are decoded from flops only, so they are clean and reset to 0
  assign rise =  sync_reg[SYNC-1] & ~dly_reg;
  assign fall = ~sync_reg[SYNC-1] &  dly_reg;

endmodule

// File: rtl/jtframe_dump_trigger.sv
// jtframe_dump_trigger
//   Produces a frame-aligned dump window for the simulation dump controller
//   (or for on-FPGA capture gating). vs and downloading are synchronised,
//   frames are counted from the end of the ROM download, and the window is
//   opened/closed when the frame count matches start_frame/stop_frame.
// Ports
//   clk          in   system clock
//   rst_n        in   asynchronous reset, active low
//   vs           in   vertical sync, asynchronous, active high
//   downloading  in   ROM download in progress, asynchronous
//   start_frame  in   first frame of the dump window (quasi-static)
//   stop_frame   in   frame at which the window closes, 0 = never
//   frame_cnt    out  frames since arming
//   vs_fall      out  one-cycle pulse per synchronised vs falling edge
//   dump_en      out  high inside the window
//   dump_start   out  one-cycle pulse when the window opens
//   dump_stop    out  one-cycle pulse when the window closes
//   cfg_err      out  sticky: non-zero stop_frame <= start_frame at arming
//   st           out  FSM state (IDLE=0 ARMED=1 DUMP=2 DONE=3)
module jtframe_dump_trigger
  import jtframe_dump_pkg::*;
#(
  parameter int CNTW    = CNTW_DEF,
  parameter int SYNC    = 2,
  parameter int WAIT_DL = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            vs,
  input  logic            downloading,
  input  logic [CNTW-1:0] start_frame,
  input  logic [CNTW-1:0] stop_frame,
  output logic [CNTW-1:0] frame_cnt,
  output logic            vs_fall,
  output logic            dump_en,
  output logic            dump_start,
  output logic            dump_stop,
  output logic            cfg_err,
  output logic [1:0]      st
);

  localparam state_t ST_RESET    = (WAIT_DL != 0) ? S_IDLE : S_ARMED;
  localparam logic   FIRST_RESET = (WAIT_DL == 0);

  logic vs_rise_unused;
  logic dl_rise, dl_fall;

  jtframe_sync_edge #(.SYNC(SYNC)) u_vs_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (vs),
    .rise  (vs_rise_unused),
    .fall  (vs_fall)
  );

  jtframe_sync_edge #(.SYNC(SYNC)) u_dl_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (downloading),
    .rise  (dl_rise),
    .fall  (dl_fall)
  );

  state_t          state_reg,  state_next;
  logic [CNTW-1:0] cnt_reg,    cnt_next;
  logic            en_reg,     en_next;
  logic            start_reg,  start_next;
  logic            stop_reg,   stop_next;
  logic            cfg_reg,    cfg_next;
  // High on the first cycle spent in ARMED; lets start_frame==0 open the
  // window without waiting for a vs edge.
  logic            first_reg,  first_next;

  logic [CNTW-1:0] cnt_inc;
  logic            cfg_bad;
  logic            open_now;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_RESET;
      cnt_reg   <= '0;
      en_reg    <= 1'b0;
      start_reg <= 1'b0;
      stop_reg  <= 1'b0;
      cfg_reg   <= 1'b0;
      first_reg <= FIRST_RESET;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      en_reg    <= en_next;
      start_reg <= start_next;
      stop_reg  <= stop_next;
      cfg_reg   <= cfg_next;
      first_reg <= first_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    en_next    = en_reg;
    start_next = 1'b0;
    stop_next  = 1'b0;
    cfg_next   = cfg_reg;
    first_next = 1'b0;
    // Wraps naturally at all-ones; comparisons use the wrapped value
    cnt_inc    = cnt_reg + {{(CNTW-1){1'b0}}, 1'b1};
    cfg_bad    = (stop_frame != '0) && (stop_frame <= start_frame);
    open_now   = (vs_fall && (cnt_inc == start_frame)) ||
                 (first_reg && (start_frame == '0));

    if (dl_rise && (state_reg != S_IDLE)) begin
      // A new download aborts everything and beats a coincident vs_fall
      state_next = S_IDLE;
      cnt_next   = '0;
      en_next    = 1'b0;
      stop_next  = en_reg;
    end else begin
      case (state_reg)
        S_IDLE: begin
          // A coincident vs_fall is deliberately not counted here
          if (dl_fall) begin
            state_next = S_ARMED;
            cnt_next   = '0;
            cfg_next   = cfg_reg | cfg_bad;
            first_next = 1'b1;
          end
        end
        S_ARMED: begin
          // Also covers arming straight out of reset, where no IDLE->ARMED
          // transition evaluated the configuration
          if (first_reg) cfg_next = cfg_reg | cfg_bad;
          if (vs_fall) cnt_next = cnt_inc;
          if (cfg_next) begin
            // Bad window: give up on the first frame boundary instead
            if (vs_fall || open_now) state_next = S_DONE;
          end else if (open_now) begin
            state_next = S_DUMP;
            en_next    = 1'b1;
            start_next = 1'b1;
          end
        end
        S_DUMP: begin
          if (vs_fall) begin
            cnt_next = cnt_inc;
            if ((stop_frame != '0) && (cnt_inc == stop_frame)) begin
              state_next = S_DONE;
              en_next    = 1'b0;
              stop_next  = 1'b1;
            end
          end
        end
        S_DONE: begin
          if (vs_fall) cnt_next = cnt_inc;
        end
        default: state_next = S_IDLE;
      endcase
    end
  end

  assign frame_cnt  = cnt_reg;
  assign dump_en    = en_reg;
  assign dump_start = start_reg;
  assign dump_stop  = stop_reg;
  assign cfg_err    = cfg_reg;
  assign st         = state_reg;

endmodule

// File: tb/tb_jtframe_dump_trigger.sv
module tb_jtframe_dump_trigger;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // DUT A: 32-bit counter, waits for download
  logic        rst_n, vs, downloading;
  logic [31:0] start_frame, stop_frame;
  logic [31:0] frame_cnt;
  logic        vs_fall, dump_en, dump_start, dump_stop, cfg_err;
  logic [1:0]  st;

  // DUT B: 4-bit counter for wrap-around
  logic        rst_n_b, vs_b, dl_b;
  logic [3:0]  start_b, stop_b;
  logic [3:0]  frame_cnt_b;
  logic        vs_fall_b, dump_en_b, dump_start_b, dump_stop_b, cfg_err_b;
  logic [1:0]  st_b;

  jtframe_dump_trigger #(.CNTW(32), .SYNC(2), .WAIT_DL(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .vs(vs), .downloading(downloading),
    .start_frame(start_frame), .stop_frame(stop_frame),
    .frame_cnt(frame_cnt), .vs_fall(vs_fall), .dump_en(dump_en),
    .dump_start(dump_start), .dump_stop(dump_stop), .cfg_err(cfg_err), .st(st)
  );

  jtframe_dump_trigger #(.CNTW(4), .SYNC(2), .WAIT_DL(1)) dut_b (
    .clk(clk), .rst_n(rst_n_b), .vs(vs_b), .downloading(dl_b),
    .start_frame(start_b), .stop_frame(stop_b),
    .frame_cnt(frame_cnt_b), .vs_fall(vs_fall_b), .dump_en(dump_en_b),
    .dump_start(dump_start_b), .dump_stop(dump_stop_b), .cfg_err(cfg_err_b), .st(st_b)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%0h", name, act);
    end
  endtask

  // Scoreboard entries: expected state when a start/stop pulse is seen
  typedef struct packed {
    logic        kind;    // 0 = dump_start, 1 = dump_stop
    logic [31:0] cnt;
    logic [1:0]  st;
    logic        en;
    logic        chk_dt;  // pulse must follow a vs_fall by exactly one cycle
  } ev_t;

  ev_t q_a[$];
  ev_t q_b[$];

  function automatic ev_t mk(input logic kind, input logic [31:0] cnt,
                             input logic [1:0] s, input logic en, input logic dt);
    ev_t e;
    e.kind = kind; e.cnt = cnt; e.st = s; e.en = en; e.chk_dt = dt;
    return e;
  endfunction

  // Monitors: pop and compare whenever a DUT presents a window pulse
  int cyc_a = 0, last_vs_a = -100;
  initial begin : mon_a
    ev_t e;
    forever begin
      @(negedge clk);
      cyc_a++;
      if (dump_start || dump_stop) begin
        if (q_a.size() == 0) begin
          checks++; errors++;
          $display("FAIL a_unexpected: start=%0b stop=%0b cnt=%0d, required no pulse",
                   dump_start, dump_stop, frame_cnt);
        end else begin
          e = q_a.pop_front();
          check("a_ev_kind", {31'd0, dump_stop}, {31'd0, e.kind});
          check("a_ev_cnt", frame_cnt, e.cnt);
          check("a_ev_st", {30'd0, st}, {30'd0, e.st});
          check("a_ev_en", {31'd0, dump_en}, {31'd0, e.en});
          if (e.chk_dt) check("a_ev_latency", cyc_a - last_vs_a, 1);
        end
      end
      if (vs_fall) last_vs_a = cyc_a;
    end
  end

  int cyc_b = 0, last_vs_b = -100;
  initial begin : mon_b
    ev_t e;
    forever begin
      @(negedge clk);
      cyc_b++;
      if (dump_start_b || dump_stop_b) begin
        if (q_b.size() == 0) begin
          checks++; errors++;
          $display("FAIL b_unexpected: start=%0b stop=%0b cnt=%0d, required no pulse",
                   dump_start_b, dump_stop_b, frame_cnt_b);
        end else begin
          e = q_b.pop_front();
          check("b_ev_kind", {31'd0, dump_stop_b}, {31'd0, e.kind});
          check("b_ev_cnt", {28'd0, frame_cnt_b}, e.cnt);
          check("b_ev_st", {30'd0, st_b}, {30'd0, e.st});
          check("b_ev_en", {31'd0, dump_en_b}, {31'd0, e.en});
          if (e.chk_dt) check("b_ev_latency", cyc_b - last_vs_b, 1);
        end
      end
      if (vs_fall_b) last_vs_b = cyc_b;
    end
  end

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_a();
    @(negedge clk); vs = 1'b1;
    wait_neg(3);    vs = 1'b0;
    wait_neg(6);
  endtask

  task automatic pulse_b();
    @(negedge clk); vs_b = 1'b1;
    wait_neg(3);    vs_b = 1'b0;
    wait_neg(6);
  endtask

  task automatic set_dl(input logic v);
    @(negedge clk); downloading = v;
    wait_neg(6);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_cnt"},   frame_cnt, 0);
    check({tag, "_en"},    {31'd0, dump_en}, 0);
    check({tag, "_start"}, {31'd0, dump_start}, 0);
    check({tag, "_stop"},  {31'd0, dump_stop}, 0);
    check({tag, "_cfg"},   {31'd0, cfg_err}, 0);
    check({tag, "_st"},    {30'd0, st}, 0);
  endtask

  task automatic reset_a();
    @(negedge clk);
    downloading = 1'b1; vs = 1'b0; rst_n = 1'b0;
    wait_neg(2);
    rst_n = 1'b1;
    wait_neg(6);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: bench still running, required finish");
    $fatal(1);
  end

  initial begin : stim
    rst_n = 1'b0; vs = 1'b0; downloading = 1'b1; start_frame = 0; stop_frame = 0;
    rst_n_b = 1'b0; vs_b = 1'b0; dl_b = 1'b1; start_b = 0; stop_b = 0;
    wait_neg(3);
    check_all_zero("reset");
    check("reset_vs_fall", {31'd0, vs_fall}, 0);
    @(negedge clk); rst_n = 1'b1; rst_n_b = 1'b1;
    wait_neg(6);
    check("idle_while_dl_st", {30'd0, st}, 0);

    // 1: window 3..5
    start_frame = 3; stop_frame = 5;
    set_dl(1'b0);
    check("t1_armed_st", {30'd0, st}, 1);
    check("t1_armed_cfg", {31'd0, cfg_err}, 0);
    q_a.push_back(mk(1'b0, 3, 2'd2, 1'b1, 1'b1));
    q_a.push_back(mk(1'b1, 5, 2'd3, 1'b0, 1'b1));
    for (int i = 1; i <= 6; i++) begin
      pulse_a();
      check($sformatf("t1_cnt_f%0d", i), frame_cnt, i);
      check($sformatf("t1_en_f%0d", i), {31'd0, dump_en}, (i == 3 || i == 4) ? 1 : 0);
    end
    check("t1_end_st", {30'd0, st}, 3);

    // 4: abort a 3..8 window at frame 4 by re-asserting downloading
    set_dl(1'b1);
    check("t4_reidle_st", {30'd0, st}, 0);
    check("t4_reidle_cnt", frame_cnt, 0);
    start_frame = 3; stop_frame = 8;
    set_dl(1'b0);
    q_a.push_back(mk(1'b0, 3, 2'd2, 1'b1, 1'b1));
    for (int i = 1; i <= 4; i++) pulse_a();
    check("t4_in_window_en", {31'd0, dump_en}, 1);
    check("t4_in_window_cnt", frame_cnt, 4);
    q_a.push_back(mk(1'b1, 0, 2'd0, 1'b0, 1'b0));
    set_dl(1'b1);
    check("t4_abort_st", {30'd0, st}, 0);
    check("t4_abort_cnt", frame_cnt, 0);
    check("t4_abort_en", {31'd0, dump_en}, 0);

    // 2: open immediately, never close
    start_frame = 0; stop_frame = 0;
    q_a.push_back(mk(1'b0, 0, 2'd2, 1'b1, 1'b0));
    set_dl(1'b0);
    check("t2_st", {30'd0, st}, 2);
    check("t2_en", {31'd0, dump_en}, 1);
    for (int i = 1; i <= 3; i++) begin
      pulse_a();
      check($sformatf("t2_cnt_f%0d", i), frame_cnt, i);
      check($sformatf("t2_en_f%0d", i), {31'd0, dump_en}, 1);
    end

    // Reset mid-window: outputs drop without waiting for a clock edge
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_all_zero("midreset");
    downloading = 1'b1;
    wait_neg(2);
    rst_n = 1'b1;
    wait_neg(6);

    // 3: bad configuration
    start_frame = 4; stop_frame = 2;
    set_dl(1'b0);
    check("t3_cfg_err", {31'd0, cfg_err}, 1);
    check("t3_armed_st", {30'd0, st}, 1);
    pulse_a();
    check("t3_done_st", {30'd0, st}, 3);
    check("t3_cnt", frame_cnt, 1);
    for (int i = 2; i <= 4; i++) pulse_a();
    check("t3_still_done", {30'd0, st}, 3);
    check("t3_no_en", {31'd0, dump_en}, 0);

    // 6: vs_fall coincident with dl_fall
    reset_a();
    start_frame = 5; stop_frame = 0;
    @(negedge clk); vs = 1'b1;
    wait_neg(6);
    vs = 1'b0; downloading = 1'b0;
    wait_neg(6);
    check("t6_armed_st", {30'd0, st}, 1);
    check("t6_cnt0", frame_cnt, 0);
    pulse_a();
    check("t6_cnt1", frame_cnt, 1);

    // 5: 4-bit counter wraps, window opens only once at frame 2
    start_b = 2; stop_b = 0;
    @(negedge clk); dl_b = 1'b0;
    wait_neg(6);
    check("t5_armed_st", {30'd0, st_b}, 1);
    q_b.push_back(mk(1'b0, 2, 2'd2, 1'b1, 1'b1));
    for (int i = 1; i <= 20; i++) begin
      pulse_b();
      check($sformatf("t5_cnt_f%0d", i), {28'd0, frame_cnt_b}, i % 16);
    end
    check("t5_end_st", {30'd0, st_b}, 2);
    check("t5_end_en", {31'd0, dump_en_b}, 1);

    wait_neg(4);
    check("a_queue_drained", q_a.size(), 0);
    check("b_queue_drained", q_b.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
